ysyx_24110006_lsu: RTL
======================

// Module: ysyx_24110006_lsu
// PURPOSE
//  Load/store unit; consumes the memory request the EXU issues (ren/wen, wmask, read_t, addr) and
//  executes it on the data bus. Sits between EXU and WBU: aligns store data/strobes, extracts and
//  sign-extends load data, passes non-memory results straight through. Same 1-cycle valid-pulse
//  handshake as the rest of the multi-cycle core.
// PARAMETERS
//  TIMEOUT  255  bus cycles to wait for i_bus_ack before aborting with o_err (8-bit counter)
// PORTS
//  i_clock        in   1   clock
//  i_reset        in   1   synchronous, active-high reset
//  i_valid        in   1   1-cycle pulse: EXU outputs below are valid this cycle
//  i_mem_ren      in   1   load request
//  i_mem_wen      in   1   store request
//  i_mem_wmask    in   4   store size mask, LSB-aligned: 0001 b, 0011 h, 1111 w
//  i_mem_read_t   in   3   load type = funct3: 000 lb,001 lh,010 lw,100 lbu,101 lhu
//  i_mem_addr     in   32  byte address
//  i_wdata        in   32  store data, LSB-aligned (rs2)
//  i_result       in   32  EXU ALU result (passed through for non-loads)
//  o_bus_req      out  1   bus request, held until ack
//  o_bus_we       out  1   1 = write
//  o_bus_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  o_bus_wdata    out  32  store data shifted left by 8*addr[1:0]
//  o_bus_wstrb    out  4   wmask shifted left by addr[1:0]; 0 on reads
//  i_bus_ack      in   1   transfer complete; i_bus_rdata valid this cycle on reads
//  i_bus_rdata    in   32  read data (full word)
//  i_bus_err      in   1   bus error, qualified by i_bus_ack
//  o_valid        out  1   1-cycle pulse: o_rdata / o_err valid
//  o_rdata        out  32  load data (extended) or pass-through i_result
//  o_err          out  1   misaligned access, bus error, or timeout; valid with o_valid
//  o_busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; o_valid, o_bus_req, o_bus_we, o_err, o_busy = 0; o_bus_wstrb = 0; data regs 0.
//  FSM IDLE -> (i_valid) capture all inputs:
//   - neither ren nor wen, or misaligned -> DONE (no bus cycle).
//   - else -> REQ. Misaligned: h with addr[0]=1, w with addr[1:0]!=0; sets o_err.
//  REQ: o_bus_req=1, addr/we/wdata/wstrb stable from registers; timer counts up each cycle.
//   - i_bus_ack -> DONE; load: latch extracted data; o_err = i_bus_err.
//   - timer == TIMEOUT-1 without ack -> DONE, o_err=1, req dropped.
//  DONE: o_valid=1 for exactly one cycle -> IDLE. o_rdata/o_err hold until next capture.
//  Latency: non-mem/misaligned: o_valid 2 cycles after i_valid. Mem: req rises cycle after
//   capture; ack in cycle N -> o_valid in N+1. ack coincident with timeout expiry: ack wins.
//  Load extract: byte = rdata[8*a+:8], half = rdata[16*a[1]+:16], a=addr[1:0]; lb/lh sign-extend,
//   lbu/lhu zero-extend; read_t 011/110/111 treated as lw. Stores: o_rdata = i_result (ignored by WB).
//  i_valid while o_busy: ignored (upstream must not issue); sim-only $fwrite warning.
//  ren && wen both set: treated as store. i_bus_ack outside REQ: ignored.
//  Reset mid-transfer: FSM to IDLE, req dropped same edge; bus must tolerate abandoned request.
// TESTING
//  1 lw addr 0x8000_0004, ack after 3 cycles rdata 0xDEAD_BEEF -> o_bus_addr 0x8000_0004, wstrb 0,
//    o_valid 1 cycle after ack, o_rdata 0xDEAD_BEEF, o_err 0.
//  2 lb addr 0x..03 rdata 0x8012_3456 -> o_rdata 0xFFFF_FF80; lbu same -> 0x0000_0080;
//    lhu addr 0x..02 -> 0x0000_8012; lh -> 0xFFFF_8012.
//  3 sh addr 0x..02 wdata 0x1234_ABCD wmask 0011 -> we=1, wstrb 1100, wdata 0xABCD_xxxx (0xABCD in [31:16]).
//  4 non-mem i_result 0x42 -> no o_bus_req, o_valid 2 cycles after i_valid, o_rdata 0x42;
//    lw addr 0x..01 -> no req, o_err 1.
//  5 lw never acked -> req held TIMEOUT cycles, then o_valid with o_err 1, req 0; ack with
//    i_bus_err=1 -> o_err 1.
//  6 reset asserted while REQ -> next cycle o_bus_req 0, o_busy 0; fresh load then completes normally.

Source files
------------

// File: rtl/ysyx_24110006_lsu_if.sv
// Data-bus interface between the LSU (master) and memory/interconnect (slave).
//   req   : request, held by the master until ack
//   we    : 1 = write
//   addr  : word-aligned byte address
//   wdata : write data, already lane-aligned
//   wstrb : byte strobes, 0 on reads
//   ack   : transfer complete; rdata/err valid this cycle
//   rdata : full read word
//   err   : bus error, qualified by ack
interface ysyx_24110006_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ack, rdata, err
    );
endinterface

// File: rtl/ysyx_24110006_lsu.sv
// Load/store unit. Takes the memory request issued by the EXU with a 1-cycle i_valid pulse,
// runs it on the data bus and returns a 1-cycle o_valid pulse to the WBU.
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_valid                   : EXU request pulse
//   i_mem_ren / i_mem_wen     : load / store request (both set = store)
//   i_mem_wmask               : store size mask, LSB-aligned (0001 b, 0011 h, 1111 w)
//   i_mem_read_t              : load funct3 (lb/lh/lw/lbu/lhu; 011/110/111 act as lw)
//   i_mem_addr                : byte address
//   i_wdata                   : store data, LSB-aligned
//   i_result                  : ALU result passed through for non-loads
//   bus                       : data-bus master port
//   o_valid                   : result pulse; o_rdata/o_err valid
//   o_rdata                   : extended load data or pass-through result
//   o_err                     : misaligned access, bus error or timeout
//   o_busy                    : FSM not idle
module ysyx_24110006_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_valid,
    input  logic                        i_mem_ren,
    input  logic                        i_mem_wen,
    input  logic [3:0]                  i_mem_wmask,
    input  logic [2:0]                  i_mem_read_t,
    input  logic [31:0]                 i_mem_addr,
    input  logic [31:0]                 i_wdata,
    input  logic [31:0]                 i_result,
    ysyx_24110006_lsu_if.master         bus,
    output logic                        o_valid,
    output logic [31:0]                 o_rdata,
    output logic                        o_err,
    output logic                        o_busy
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    // StPass stands in for the bus slot so non-memory ops see the same 2-cycle latency
    // as a zero-wait bus access.
    typedef enum logic [1:0] {StIdle, StPass, StReq, StDone} state_e;

    state_e      state_q;
    logic        valid_q;
    logic        req_q;
    logic        we_q;
    logic [29:0] addr_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  read_t_q;
    logic [7:0]  timer_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        is_mem;
    logic        is_word;
    logic        is_half;
    logic        misaligned;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;

    // Access size comes from wmask for stores and from read_t for loads; store wins.
    always_comb begin
        is_mem = i_mem_ren | i_mem_wen;
        if (i_mem_wen) begin
            is_word = i_mem_wmask[3];
            is_half = ~i_mem_wmask[3] & i_mem_wmask[1];
        end else begin
            is_word = i_mem_read_t[1];
            is_half = (i_mem_read_t[1:0] == 2'b01);
        end
        misaligned = (is_word & (i_mem_addr[1:0] != 2'b00)) | (is_half & i_mem_addr[0]);
    end

    // read_t[2] marks the unsigned variants.
    always_comb begin
        byte_v = bus.rdata[{off_q, 3'b000} +: 8];
        half_v = bus.rdata[{off_q[1], 4'b0000} +: 16];
        if (read_t_q[1]) begin
            load_data = bus.rdata;
        end else if (read_t_q[0]) begin
            load_data = {{16{half_v[15] & ~read_t_q[2]}}, half_v};
        end else begin
            load_data = {{24{byte_v[7] & ~read_t_q[2]}}, byte_v};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            off_q    <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            read_t_q <= '0;
            timer_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        rdata_q <= i_result;
                        err_q   <= is_mem & misaligned;
                        if (is_mem && !misaligned) begin
                            state_q  <= StReq;
                            req_q    <= 1'b1;
                            we_q     <= i_mem_wen;
                            addr_q   <= i_mem_addr[31:2];
                            off_q    <= i_mem_addr[1:0];
                            wdata_q  <= i_wdata << {i_mem_addr[1:0], 3'b000};
                            wstrb_q  <= i_mem_wen ? (i_mem_wmask << i_mem_addr[1:0]) : 4'b0000;
                            read_t_q <= i_mem_read_t;
                            timer_q  <= '0;
                        end else begin
                            state_q <= StPass;
                        end
                    end
                end
                StPass: begin
                    state_q <= StDone;
                    valid_q <= 1'b1;
                end
                StReq: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (bus.ack) begin
                        state_q <= StDone;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        err_q   <= bus.err;
                        if (!we_q) begin
                            rdata_q <= load_data;
                        end
                    end else if (timer_q == TimeoutLast) begin
                        state_q <= StDone;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge i_clock) begin
        if (!i_reset && i_valid && state_q != StIdle) begin
            $display("ysyx_24110006_lsu: warning: i_valid ignored while busy");
        end
    end
`endif

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = {addr_q, 2'b00};
    assign bus.wdata = wdata_q;
    assign bus.wstrb = wstrb_q;

    assign o_valid = valid_q;
    assign o_rdata = rdata_q;
    assign o_err   = err_q;
    assign o_busy  = (state_q != StIdle);

endmodule
